alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_sequencer_op_decode.sv | 18 +
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM states and sizing for the ALU sequencer.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NUM_OPS    = 13;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_SHR  = 4;
    localparam int OP_SHRA = 5;
    localparam int OP_SHL  = 6;
    localparam int OP_ROR  = 7;
    localparam int OP_ROL  = 8;
    localparam int OP_MUL  = 9;
    localparam int OP_DIV  = 10;
    localparam int OP_NEG  = 11;
    localparam int OP_NOT  = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_CAPT,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_sequencer_op_decode.sv
// Opcode to one-hot ALU strobe vector; bit index equals opcode value.
module op_decode
    import alu_pkg::*;
(
    input  logic [4:0]         opcode,
    output logic [NUM_OPS-1:0] strb,
    output logic               legal
);

    always_comb begin
        legal = (opcode < 5'(NUM_OPS));
        strb  = '0;
        if (legal) begin
            strb = {{(NUM_OPS-1){1'b0}}, 1'b1} << opcode;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: latch, strobe, capture, hand off.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [4:0]          opcode,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    output logic [DATA_W-1:0]   y_out,
    output logic [DATA_W-1:0]   a_out,
    output logic [DATA_W-1:0]   b_out,
    output logic                alu_add,
    output logic                alu_sub,
    output logic                alu_and,
    output logic                alu_or,
    output logic                alu_shr,
    output logic                alu_shra,
    output logic                alu_shl,
    output logic                alu_ror,
    output logic                alu_rol,
    output logic                alu_mul,
    output logic                alu_div,
    output logic                alu_neg,
    output logic                alu_not,
    input  logic [2*DATA_W-1:0] alu_c,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   z_hi,
    output logic [DATA_W-1:0]   z_lo,
    output logic                err_div0,
    output logic                err_badop
);

    state_t               r_state;
    state_t               w_next;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [NUM_OPS-1:0]   r_strb;
    logic [DATA_W-1:0]    r_zhi;
    logic [DATA_W-1:0]    r_zlo;
    logic                 r_err_div0;
    logic                 r_err_badop;
    logic [NUM_OPS-1:0]   w_dec_strb;
    logic                 w_legal;
    logic [NUM_OPS-1:0]   w_strb;
    logic                 w_accept;
    logic                 w_div0;
    logic                 w_fast;
    logic                 w_wide;

    op_decode u_dec (
        .opcode (opcode),
        .strb   (w_dec_strb),
        .legal  (w_legal)
    );

    assign w_accept = op_valid & op_ready;
    assign w_div0   = w_legal & w_dec_strb[OP_DIV] & (src_b == '0);
    // Errors skip the ALU entirely and report straight from DONE.
    assign w_fast   = ~w_legal | w_div0;
    assign w_wide   = r_strb[OP_MUL] | r_strb[OP_DIV];

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_fast ? S_DONE : S_LOAD;
            end
            S_LOAD: w_next = S_EXEC;
            S_EXEC: w_next = S_CAPT;
            S_CAPT: w_next = S_DONE;
            S_DONE: begin
                if (w_accept)       w_next = w_fast ? S_DONE : S_LOAD;
                else if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & res_ready);
        res_valid = (r_state == S_DONE);
        w_strb    = (r_state == S_EXEC) ? r_strb : '0;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_a         <= '0;
            r_b         <= '0;
            r_strb      <= '0;
            r_zhi       <= '0;
            r_zlo       <= '0;
            r_err_div0  <= 1'b0;
            r_err_badop <= 1'b0;
        end else if (w_accept) begin
            r_a         <= src_a;
            r_b         <= src_b;
            r_strb      <= w_dec_strb;
            r_zhi       <= '0;
            r_zlo       <= '0;
            r_err_div0  <= w_div0;
            r_err_badop <= ~w_legal;
        end else if (r_state == S_CAPT) begin
            r_zlo <= alu_c[DATA_W-1:0];
            r_zhi <= w_wide ? alu_c[2*DATA_W-1:DATA_W] : '0;
        end
    end

    assign y_out     = r_a;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign z_hi      = r_zhi;
    assign z_lo      = r_zlo;
    assign err_div0  = r_err_div0;
    assign err_badop = r_err_badop;

    assign alu_add  = w_strb[OP_ADD];
    assign alu_sub  = w_strb[OP_SUB];
    assign alu_and  = w_strb[OP_AND];
    assign alu_or   = w_strb[OP_OR];
    assign alu_shr  = w_strb[OP_SHR];
    assign alu_shra = w_strb[OP_SHRA];
    assign alu_shl  = w_strb[OP_SHL];
    assign alu_ror  = w_strb[OP_ROR];
    assign alu_rol  = w_strb[OP_ROL];
    assign alu_mul  = w_strb[OP_MUL];
    assign alu_div  = w_strb[OP_DIV];
    assign alu_neg  = w_strb[OP_NEG];
    assign alu_not  = w_strb[OP_NOT];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a registered behavioural ALU.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clear = 1'b1;
    logic           op_valid = 1'b0;
    logic           res_ready = 1'b0;
    logic [4:0]     opcode = '0;
    logic [W-1:0]   src_a = '0;
    logic [W-1:0]   src_b = '0;
    logic [2*W-1:0] alu_c = '0;
    logic           op_ready, res_valid, err_div0, err_badop;
    logic [W-1:0]   y_out, a_out, b_out, z_hi, z_lo;
    logic alu_add, alu_sub, alu_and, alu_or, alu_shr, alu_shra, alu_shl;
    logic alu_ror, alu_rol, alu_mul, alu_div, alu_neg, alu_not;
    logic [NUM_OPS-1:0] strb;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         e0;
        logic         eb;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails = 0;

    alu_sequencer #(.DATA_W(W)) dut (
        .clk(clk), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .src_a(src_a), .src_b(src_b),
        .y_out(y_out), .a_out(a_out), .b_out(b_out),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and),
        .alu_or(alu_or), .alu_shr(alu_shr), .alu_shra(alu_shra),
        .alu_shl(alu_shl), .alu_ror(alu_ror), .alu_rol(alu_rol),
        .alu_mul(alu_mul), .alu_div(alu_div), .alu_neg(alu_neg),
        .alu_not(alu_not), .alu_c(alu_c), .res_valid(res_valid),
        .res_ready(res_ready), .z_hi(z_hi), .z_lo(z_lo),
        .err_div0(err_div0), .err_badop(err_badop)
    );

    assign strb = {alu_not, alu_neg, alu_div, alu_mul, alu_rol, alu_ror,
                   alu_shl, alu_shra, alu_shr, alu_or, alu_and, alu_sub,
                   alu_add};

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_alu(input logic [4:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] r;
        int s;
        s = int'(b[4:0]);
        r = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a >> s;
            5'd5:  r = $signed(a) >>> s;
            5'd6:  r = a << s;
            5'd7:  r = (a >> s) | (a << (W - s));
            5'd8:  r = (a << s) | (a >> (W - s));
            5'd9:  return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            5'd10: return (b == '0) ? '0 : {a % b, a / b};
            5'd11: r = -a;
            5'd12: r = ~a;
            default: r = '0;
        endcase
        return {{W{1'b0}}, r};
    endfunction

    function automatic exp_t expect_of(input logic [4:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] r;
        e = '0;
        if (op > 5'd12) begin
            e.eb = 1'b1;
        end else if (op == 5'd10 && b == '0) begin
            e.e0 = 1'b1;
        end else begin
            r = ref_alu(op, a, b);
            e.lo = r[W-1:0];
            if (op == 5'd9 || op == 5'd10) e.hi = r[2*W-1:W];
        end
        return e;
    endfunction

    // Registered ALU: result appears the cycle after its strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_OPS; i++) begin
            if (strb[i]) alu_c <= ref_alu(5'(i), a_out, b_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op_valid = 1'b1; opcode = 5'd0; src_a = 32'd3; src_b = 32'd4;
        clear = 1'b1;
        step();
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs got=%b%b exp=10", op_ready, res_valid);
        end
        checks++;
        if (strb !== '0 || {err_div0, err_badop} !== 2'b00) begin
            fails++;
            $display("FAIL reset_strb got=%h/%b%b exp=0", strb, err_div0, err_badop);
        end
        checks++;
        if ({y_out, a_out, b_out, z_hi, z_lo} !== '0) begin
            fails++;
            $display("FAIL reset_data a=%h b=%h zh=%h zl=%h exp=0", a_out, b_out, z_hi, z_lo);
        end
        clear = 1'b0; op_valid = 1'b0;
        step();
    endtask

    task automatic test_add();
        exp_t e;
        opcode = 5'd0; src_a = 32'd5; src_b = 32'd7; op_valid = 1'b1; res_ready = 1'b1;
        sb.push_back(expect_of(5'd0, 32'd5, 32'd7));
        step();
        op_valid = 1'b0; opcode = 5'd12; src_a = 32'd99; src_b = 32'd1;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (strb !== ((c == 2) ? 13'h0001 : 13'h0000)) begin
                fails++; $display("FAIL add_strb c=%0d got=%h", c, strb);
            end
            checks++;
            if (res_valid !== (c == 4) || op_ready !== (c >= 4)) begin
                fails++; $display("FAIL add_hs c=%0d got=%b%b", c, res_valid, op_ready);
            end
            if (res_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({z_hi, z_lo, err_div0, err_badop} !== e) begin
                    fails++;
                    $display("FAIL add_res got=%h_%h exp=%h_%h", z_hi, z_lo, e.hi, e.lo);
                end
            end
            step();
        end
        checks++;
        if (y_out !== 32'd5 || a_out !== 32'd5 || b_out !== 32'd7) begin
            fails++; $display("FAIL add_hold a=%0d b=%0d exp=5,7", a_out, b_out);
        end
    endtask

    task automatic test_mul();
        exp_t e;
        opcode = 5'd9; src_a = 32'hFFFF_FFFF; src_b = 32'd2; op_valid = 1'b1;
        sb.push_back(expect_of(5'd9, 32'hFFFF_FFFF, 32'd2));
        step();
        op_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (strb !== ((c == 2) ? 13'h0200 : 13'h0000)) begin
                fails++; $display("FAIL mul_strb c=%0d got=%h", c, strb);
            end
            if (c == 4) begin
                e = sb.pop_front();
                checks++;
                if (res_valid !== 1'b1 || {z_hi, z_lo, err_div0, err_badop} !== e) begin
                    fails++;
                    $display("FAIL mul_res v=%b got=%h_%h exp=%h_%h", res_valid, z_hi, z_lo, e.hi, e.lo);
                end
            end
            step();
        end
    endtask

    task automatic test_div0();
        exp_t e;
        opcode = 5'd10; src_a = 32'd100; src_b = 32'd0; op_valid = 1'b1;
        sb.push_back(expect_of(5'd10, 32'd100, 32'd0));
        step();
        op_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (strb !== '0 || res_valid !== (c == 1)) begin
                fails++; $display("FAIL div0_seq c=%0d strb=%h v=%b", c, strb, res_valid);
            end
            if (c == 1) begin
                e = sb.pop_front();
                checks++;
                if ({z_hi, z_lo, err_div0, err_badop} !== e) begin
                    fails++;
                    $display("FAIL div0_res got=%h_%h e=%b%b exp=%h_%h e=%b%b", z_hi, z_lo, err_div0, err_badop, e.hi, e.lo, e.e0, e.eb);
                end
            end
            step();
        end
    endtask

    task automatic test_badop();
        exp_t e;
        opcode = 5'd20; src_a = 32'd1; src_b = 32'd2; op_valid = 1'b1; res_ready = 1'b0;
        sb.push_back(expect_of(5'd20, 32'd1, 32'd2));
        step();
        op_valid = 1'b0;
        e = sb[0];
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (res_valid !== 1'b1 || op_ready !== 1'b0 || strb !== '0) begin
                fails++; $display("FAIL badop_hold c=%0d v=%b r=%b s=%h", c, res_valid, op_ready, strb);
            end
            checks++;
            if ({z_hi, z_lo, err_div0, err_badop} !== e) begin
                fails++;
                $display("FAIL badop_res c=%0d got=%h_%h e=%b%b exp e=%b%b", c, z_hi, z_lo, err_div0, err_badop, e.e0, e.eb);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b1) begin
            fails++; $display("FAIL badop_ready got=%b exp=1", op_ready);
        end
        void'(sb.pop_front());
        step();
        checks++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
            fails++; $display("FAIL badop_retire v=%b r=%b exp=0,1", res_valid, op_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [NUM_OPS-1:0] es;
        opcode = 5'd1; src_a = 32'd9; src_b = 32'd4; op_valid = 1'b1; res_ready = 1'b1;
        sb.push_back(expect_of(5'd1, 32'd9, 32'd4));
        step();
        opcode = 5'd3; src_a = 32'h0000_00F0; src_b = 32'h0000_000F;
        for (int c = 1; c <= 9; c++) begin
            es = (c == 2) ? 13'h0002 : (c == 6) ? 13'h0008 : 13'h0000;
            checks++;
            if (strb !== es || res_valid !== (c == 4 || c == 8)) begin
                fails++; $display("FAIL b2b_seq c=%0d strb=%h exp=%h v=%b", c, strb, es, res_valid);
            end
            if (c == 4) begin
                checks++;
                if (op_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_ready got=%b exp=1", op_ready);
                end
                sb.push_back(expect_of(5'd3, 32'h0000_00F0, 32'h0000_000F));
            end
            if (c == 5) begin
                checks++;
                if (a_out !== 32'h0000_00F0 || op_ready !== 1'b0) begin
                    fails++; $display("FAIL b2b_nobubble a=%h r=%b exp=f0,0", a_out, op_ready);
                end
            end
            if (res_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({z_hi, z_lo, err_div0, err_badop} !== e) begin
                    fails++;
                    $display("FAIL b2b_res c=%0d got=%h_%h exp=%h_%h", c, z_hi, z_lo, e.hi, e.lo);
                end
            end
            if (c == 8) op_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_clear_mid_exec();
        opcode = 5'd8; src_a = 32'h8000_0001; src_b = 32'd1; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        checks++;
        if (strb !== 13'h0100) begin
            fails++; $display("FAIL clr_exec got=%h exp=0100", strb);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (strb !== '0 || op_ready !== 1'b1 || a_out !== '0) begin
            fails++; $display("FAIL clr_idle strb=%h r=%b a=%h", strb, op_ready, a_out);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (res_valid !== 1'b0) begin
                fails++; $display("FAIL clr_noresult c=%0d v=%b exp=0", c, res_valid);
            end
            step();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_mul();
        test_div0();
        test_badop();
        test_back_to_back();
        test_clear_mid_exec();
        checks++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL sb_empty left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
